serial_frame_deser: RTL and testbench

Downstream consumer of the bit-delay (slap) pipeline stage. It takes that stage's delayed serial output one bit at a time and hunts for a sync word. After sync it assembles fixed-width words MSB-first and buffers them in a small FIFO. Words are presented on a valid/ready output port; the block also reports lock status, overflow and a completed-frame count.

---
 rtl/serial_frame_deser.sv | 143 ++++++++++++++
 tb/tb_serial_frame_deser.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// Serial frame deserializer: hunts for a sync word in a qualified bit stream,
// then assembles MSB-first words into a small valid/ready output FIFO.
module serial_frame_deser #(
  parameter int unsigned       WIDTH           = 8,
  parameter int unsigned       SYNC_W          = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD       = SYNC_W'(8'hA5),
  parameter int unsigned       WORDS_PER_FRAME = 2,
  parameter int unsigned       DEPTH           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sync_lock,
  output logic             overflow,
  output logic [7:0]       frames_done
);

  localparam int unsigned HCW = $clog2(SYNC_W + 1);
  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned WCW = $clog2(WORDS_PER_FRAME + 1);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef enum logic {HUNT, COLLECT} state_e;

  state_e            state_q, state_d;
  logic [SYNC_W-2:0] shreg_q, shreg_d;
  logic [HCW-1:0]    hunt_cnt_q, hunt_cnt_d;
  logic [WIDTH-2:0]  word_q, word_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [7:0]        frames_q, frames_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [SYNC_W-1:0] shreg_nxt_c;
  logic [WIDTH-1:0]  push_word_c;
  logic              push_c, pop_c, full_c, accept_c;

  // Hunt / collect next-state logic; only bit_en cycles advance the datapath.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hunt_cnt_d  = hunt_cnt_q;
    word_d      = word_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    frames_d    = frames_q;
    push_c      = 1'b0;
    shreg_nxt_c = {shreg_q, bit_in};
    push_word_c = {word_q, bit_in};
    if (bit_en) begin
      case (state_q)
        HUNT: begin
          shreg_d = shreg_nxt_c[SYNC_W-2:0];
          if (hunt_cnt_q != HCW'(SYNC_W)) hunt_cnt_d = hunt_cnt_q + HCW'(1);
          if (shreg_nxt_c == SYNC_WORD && hunt_cnt_q >= HCW'(SYNC_W - 1)) begin
            state_d    = COLLECT;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        COLLECT: begin
          word_d = push_word_c[WIDTH-2:0];
          if (bit_cnt_q == BCW'(WIDTH - 1)) begin
            push_c    = 1'b1;
            bit_cnt_d = '0;
            if (word_cnt_q == WCW'(WORDS_PER_FRAME - 1)) begin
              word_cnt_d = '0;
              frames_d   = frames_q + 8'd1;
              state_d    = HUNT;
              shreg_d    = '0;
              hunt_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // FIFO bookkeeping; a pop in the same cycle frees room for a push when full.
  always_comb begin
    pop_c    = valid_q && m_ready;
    full_c   = (count_q == CW'(DEPTH));
    accept_c = push_c && (!full_c || pop_c);
    ovf_d    = push_c && full_c && !pop_c;
    rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = accept_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(accept_c) - CW'(pop_c);
    valid_d  = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      shreg_q    <= '0;
      hunt_cnt_q <= '0;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      frames_q   <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      hunt_cnt_q <= hunt_cnt_d;
      word_q     <= word_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      frames_q   <= frames_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (accept_c) mem_q[wr_ptr_q] <= push_word_c;
    end
  end

  assign m_data      = mem_q[rd_ptr_q];
  assign m_valid     = valid_q;
  assign sync_lock   = (state_q == COLLECT);
  assign overflow    = ovf_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Bench for serial_frame_deser: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_serial_frame_deser;

  localparam int unsigned SYNC_W = 8;
  localparam int unsigned WPF    = 2;
  localparam int unsigned DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0, bit_en = 1'b0, m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, sync_lock, overflow;
  logic [7:0] frames_done;
  logic [7:0] m_data05;
  logic       m_valid05, lock05, ovf05;
  logic [7:0] frames05;

  always #5 clk = ~clk;

  serial_frame_deser u_dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .sync_lock(sync_lock), .overflow(overflow), .frames_done(frames_done)
  );

  serial_frame_deser #(.SYNC_WORD(8'h05)) u_dut05 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
    .m_data(m_data05), .m_valid(m_valid05), .m_ready(m_ready),
    .sync_lock(lock05), .overflow(ovf05), .frames_done(frames05)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: bit history since hunt entry, word accumulator, FIFO queue.
  bit         md_locked;
  bit         md_hist[$];
  int         md_wbits, md_nwords;
  logic [7:0] md_wacc;
  logic [7:0] md_fifo[$];
  logic [7:0] md_frames;
  bit         md_ovf;

  function automatic void model_reset();
    md_locked = 0; md_hist.delete(); md_wbits = 0; md_nwords = 0;
    md_wacc = 8'h00; md_fifo.delete(); md_frames = 8'h00; md_ovf = 0;
  endfunction

  function automatic void model_step(bit b, bit en, bit rdy);
    bit         pop, done;
    logic [7:0] word, win;
    pop = (md_fifo.size() > 0) && rdy;
    done = 0; word = 8'h00; md_ovf = 0;
    if (en) begin
      if (!md_locked) begin
        md_hist.push_back(b);
        if (md_hist.size() > SYNC_W) void'(md_hist.pop_front());
        if (md_hist.size() == SYNC_W) begin
          win = 8'h00;
          foreach (md_hist[i]) win = {win[6:0], md_hist[i]};
          if (win == 8'hA5) begin md_locked = 1; md_wbits = 0; md_nwords = 0; end
        end
      end else begin
        md_wacc = {md_wacc[6:0], b};
        md_wbits++;
        if (md_wbits == 8) begin
          done = 1; word = md_wacc; md_wbits = 0; md_nwords++;
          if (md_nwords == WPF) begin
            md_frames = md_frames + 8'd1; md_locked = 0; md_hist.delete();
          end
        end
      end
    end
    if (pop) void'(md_fifo.pop_front());
    if (done) begin
      if (md_fifo.size() < DEPTH) md_fifo.push_back(word);
      else md_ovf = 1;
    end
  endfunction

  task automatic compare_all();
    chk("m_valid", 32'(m_valid), 32'(md_fifo.size() > 0));
    if (md_fifo.size() > 0) chk("m_data", 32'(m_data), 32'(md_fifo[0]));
    chk("sync_lock", 32'(sync_lock), 32'(md_locked));
    chk("overflow", 32'(overflow), 32'(md_ovf));
    chk("frames_done", 32'(frames_done), 32'(md_frames));
  endtask

  // One clock: drive at negedge, model steps at posedge, compare at next negedge.
  task automatic cyc(input logic b, input logic en, input logic rdy);
    bit_in = b; bit_en = en; m_ready = rdy;
    @(posedge clk);
    model_step(b, en, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_lock", 32'(sync_lock), 32'h0);
    chk("rst_frames", 32'(frames_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rdy);
    for (int i = 7; i >= 0; i--) cyc(v[i], 1'b1, rdy);
  endtask

  // Fills the FIFO with 0x01..0x04 (two frames) and leaves the block locked.
  task automatic fill_four();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
    send_byte(8'hA5, 1'b0);
  endtask

  typedef struct {
    logic       b;
    logic       exp_lock;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] exp_frames;
  } vec_t;

  vec_t        tv[24];
  logic [23:0] stream;
  logic [8:0]  slide;
  logic [7:0]  v05;
  logic [7:0]  sw;
  int          kind, gaps;

  initial begin
    stream = {8'hA5, 8'h3C, 8'hF0};
    for (int i = 0; i < 24; i++) begin
      tv[i].b          = stream[23 - i];
      tv[i].exp_lock   = (i >= 7 && i <= 22);
      tv[i].exp_valid  = (i == 15 || i == 23);
      tv[i].exp_data   = (i == 15) ? 8'h3C : 8'hF0;
      tv[i].exp_frames = (i == 23) ? 8'd1 : 8'd0;
    end

    // Basic frame from the vector table
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cyc(tv[i].b, 1'b1, 1'b1);
      chk("t1_lock", 32'(sync_lock), 32'(tv[i].exp_lock));
      chk("t1_valid", 32'(m_valid), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) chk("t1_data", 32'(m_data), 32'(tv[i].exp_data));
      chk("t1_frames", 32'(frames_done), 32'(tv[i].exp_frames));
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("t1_drained", 32'(m_valid), 32'h0);

    // Sliding match, continuous then every other cycle enabled
    slide = 9'b110100101;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(slide[8 - i], 1'b1, 1'b1);
      chk("t2_lock", 32'(sync_lock), 32'(i == 8));
    end
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(slide[8 - i], 1'b1, 1'b1);
      chk("t2g_lock_en", 32'(sync_lock), 32'(i == 8));
      if (i < 8) begin
        cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        chk("t2g_lock_gap", 32'(sync_lock), 32'h0);
      end
    end

    // Sync pattern with leading zeros must not match on the reset-cleared history
    v05 = 8'h05;
    do_reset();
    cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
    chk("t3_nolock", 32'(lock05), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(v05[7 - i], 1'b1, 1'b1);
      chk("t3_lock", 32'(lock05), 32'(i == 7));
    end

    // Overflow while stalled, then drain
    do_reset();
    fill_four();
    send_byte(8'h05, 1'b0);
    chk("t4_ovf", 32'(overflow), 32'h1);
    chk("t4_hold", 32'(m_data), 32'h01);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_ovf_pulse", 32'(overflow), 32'h0);
    chk("t4_hold2", 32'(m_data), 32'h01);
    for (int k = 1; k <= 4; k++) begin
      chk("t4_valid", 32'(m_valid), 32'h1);
      chk("t4_order", 32'(m_data), 32'(k));
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("t4_empty", 32'(m_valid), 32'h0);

    // Full FIFO with a pop in the completing cycle accepts the word
    do_reset();
    fill_four();
    sw = 8'h05;
    for (int i = 7; i >= 1; i--) cyc(sw[i], 1'b1, 1'b0);
    chk("t5_head", 32'(m_data), 32'h01);
    cyc(sw[0], 1'b1, 1'b1);
    chk("t5_noovf", 32'(overflow), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      chk("t5_order", 32'(m_data), 32'(k));
      cyc(1'b0, 1'b0, 1'b1);
    end
    chk("t5_empty", 32'(m_valid), 32'h0);

    // Reset mid-word discards state; stale bits cannot complete a match
    do_reset();
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'hA5, 1'b0);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    chk("t6_pre_lock", 32'(sync_lock), 32'h1);
    chk("t6_pre_frames", 32'(frames_done), 32'h1);
    do_reset();
    stream = {12'b0101_1010_0101, 12'h000};
    for (int i = 0; i < 12; i++) begin
      cyc(stream[23 - i], 1'b1, 1'b1);
      chk("t6_lock", 32'(sync_lock), 32'(i == 11));
    end

    // Random traffic against the model
    do_reset();
    for (int s = 0; s < 300; s++) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        do_reset();
      end else if (kind < 9) begin
        sw = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
          gaps = int'($urandom_range(0, 2));
          for (int g = 0; g < gaps; g++)
            cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 2) == 0));
          cyc(sw[i], 1'b1, 1'($urandom_range(0, 2) == 0));
        end
      end else begin
        for (int i = 0; i < 12; i++)
          cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 2) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
